// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (priority) and the
// loader/debug port, with starvation protection, exclusive lock and error screening.
module imem_port_arbiter #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned AW         = 10,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_valid,
  input  logic [31:0]   f_addr,
  output logic          f_ready,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_valid,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  input  logic          l_lock,
  output logic          l_ready,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  output logic          locked,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;
  logic          r_resp_pending;
  logic          r_resp_port;
  logic          r_resp_err;
  logic          r_resp_we;

  logic          w_locked;
  logic          w_starve;
  logic          w_f_err;
  logic          w_l_err;
  logic          w_f_grant;
  logic          w_l_grant;
  logic [31:0]   w_resp_data;

  // Word-aligned and inside the memory, otherwise the access is refused.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  assign w_locked = (r_state == ST_LOCKED);
  assign w_starve = (r_starve_cnt == SW'(MAX_STARVE));
  assign w_f_err  = addr_err(f_addr);
  assign w_l_err  = addr_err(l_addr);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: lock follows l_lock with one cycle of latency
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (l_lock)  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (!l_lock) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Grants are suppressed while reset is held so the memory stays idle.
  always_comb begin
    w_l_grant = 1'b0;
    w_f_grant = 1'b0;
    if (rst) begin
      w_l_grant = l_valid & (w_locked | !f_valid | w_starve);
      w_f_grant = f_valid & !w_locked & !w_l_grant;
    end
  end

  assign l_ready = w_l_grant;
  assign f_ready = w_f_grant;
  assign locked  = rst & w_locked;

  // Memory drive from the granted port; erroring requests never reach the array
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = l_wdata;
    if (w_l_grant) begin
      mem_en   = !w_l_err;
      mem_we   = l_we & !w_l_err;
      mem_addr = l_addr[AW+1:2];
    end else if (w_f_grant) begin
      mem_en   = !w_f_err;
      mem_addr = f_addr[AW+1:2];
    end
  end

  // Starvation counter: counts fetch wins while the loader is waiting
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_l_grant || !l_valid) begin
      w_starve_nxt = '0;
    end else if (w_f_grant && !w_starve) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Response tracking aligned with the memory's one-cycle read latency
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_pending <= 1'b0;
      r_resp_port    <= 1'b0;
      r_resp_err     <= 1'b0;
      r_resp_we      <= 1'b0;
    end else begin
      r_resp_pending <= w_l_grant | w_f_grant;
      r_resp_port    <= w_l_grant;
      r_resp_err     <= w_l_grant ? w_l_err : w_f_err;
      r_resp_we      <= w_l_grant & l_we;
    end
  end

  assign w_resp_data = (r_resp_err || r_resp_we) ? 32'h0 : mem_rdata;

  assign f_rvalid = rst & r_resp_pending & !r_resp_port;
  assign f_err    = f_rvalid & r_resp_err;
  assign f_rdata  = f_rvalid ? w_resp_data : 32'h0;

  assign l_rvalid = rst & r_resp_pending & r_resp_port;
  assign l_err    = l_rvalid & r_resp_err;
  assign l_rdata  = l_rvalid ? w_resp_data : 32'h0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural memory and a response scoreboard.
module tb_imem_port_arbiter;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk;
  logic          rst;
  logic          f_valid;
  logic [31:0]   f_addr;
  logic          f_ready;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_valid;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_lock;
  logic          l_ready;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;
  logic          locked;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] tb_mem  [DEPTH];
  int          n_checks;
  int          n_fail;
  string       phase;

  imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_ready(l_ready), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata), .l_err(l_err), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr];
    end
  end

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s %s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  // One cycle: check responses due now, check grants, record expected responses.
  task automatic tick(input logic ef, input logic el, input logic elk);
    resp_t e;
    logic  fe;
    logic  le;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!e.port) begin
        chk("f_rvalid", 32'(f_rvalid), 32'h1);
        chk("f_err",    32'(f_err),    32'(e.err));
        chk("f_rdata",  f_rdata,       e.data);
        chk("l_rvalid", 32'(l_rvalid), 32'h0);
      end else begin
        chk("l_rvalid", 32'(l_rvalid), 32'h1);
        chk("l_err",    32'(l_err),    32'(e.err));
        chk("l_rdata",  l_rdata,       e.data);
        chk("f_rvalid", 32'(f_rvalid), 32'h0);
      end
    end else begin
      chk("f_rvalid idle", 32'(f_rvalid), 32'h0);
      chk("l_rvalid idle", 32'(l_rvalid), 32'h0);
    end
    chk("locked",  32'(locked),  32'(elk));
    chk("f_ready", 32'(f_ready), 32'(ef));
    chk("l_ready", 32'(l_ready), 32'(el));
    fe = exp_err(f_addr);
    le = exp_err(l_addr);
    chk("mem_en", 32'(mem_en), 32'((el & !le) | (ef & !fe)));
    if (el) begin
      chk("mem_we", 32'(mem_we), 32'(l_we & !le));
      e.port = 1'b1;
      e.err  = le;
      e.data = (le || l_we) ? 32'h0 : exp_mem[l_addr[AW+1:2]];
      if (l_we && !le) exp_mem[l_addr[AW+1:2]] = l_wdata;
      exp_q.push_back(e);
    end else if (ef) begin
      chk("mem_we", 32'(mem_we), 32'h0);
      e.port = 1'b0;
      e.err  = fe;
      e.data = fe ? 32'h0 : exp_mem[f_addr[AW+1:2]];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; f_valid = 1'b1; f_addr = 32'h2;
    l_valid = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;

    phase = "reset";
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    phase = "err_fetch";
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0);

    phase = "lock";
    f_valid = 1'b0; l_lock = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    phase = "preload";
    f_valid = 1'b1; f_addr = 32'h0; l_valid = 1'b1; l_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      l_addr  = 32'(i * 4);
      l_wdata = 32'(i * 32'h80 + 32'h13);
      tick(1'b0, 1'b1, 1'b1);
    end

    phase = "write20";
    l_addr = 32'h20; l_wdata = 32'hDEADBEEF;
    tick(1'b0, 1'b1, 1'b1);

    phase = "oob_write";
    l_addr = 32'(4 * DEPTH); l_wdata = 32'hBAD0BAD0;
    tick(1'b0, 1'b1, 1'b1);

    phase = "release";
    l_valid = 1'b0; l_we = 1'b0; l_lock = 1'b0;
    tick(1'b0, 1'b0, 1'b1);

    phase = "fetch_stream";
    for (int i = 0; i < 4; i++) begin
      f_addr = 32'(i * 4);
      tick(1'b1, 1'b0, 1'b0);
    end
    phase = "fetch20";
    f_addr = 32'h20;
    tick(1'b1, 1'b0, 1'b0);

    phase = "starve";
    l_valid = 1'b1; l_we = 1'b0; l_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      f_addr = 32'(i * 4);
      tick(1'b1, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b0);

    phase = "loader_read";
    f_valid = 1'b0; l_addr = 32'h20;
    tick(1'b0, 1'b1, 1'b0);
    l_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    phase = "rst_mid";
    f_valid = 1'b1; f_addr = 32'h4; l_valid = 1'b1; l_addr = 32'h10;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    l_lock = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    exp_q.delete();
    rst = 1'b0; l_lock = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    phase = "post_rst";
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    l_valid = 1'b0; f_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
